// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single mem port between two requesters.
// Round-robin with a bounded lock; req to ack is three cycles.
`ifndef ADDR_BUS
  `define ADDR_BUS 32
`endif
`ifndef DATA_BUS
  `define DATA_BUS 32
`endif

module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [`ADDR_BUS-1:0] m0_addr_i,
  input  logic [3:0]           m0_width_i,
  input  logic [`DATA_BUS-1:0] m0_wdata_i,
  input  logic                 m0_lock_i,
  output logic                 m0_ack_o,
  output logic [`DATA_BUS-1:0] m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [`ADDR_BUS-1:0] m1_addr_i,
  input  logic [3:0]           m1_width_i,
  input  logic [`DATA_BUS-1:0] m1_wdata_i,
  input  logic                 m1_lock_i,
  output logic                 m1_ack_o,
  output logic [`DATA_BUS-1:0] m1_rdata_o,
  output logic                 mem_ce_o,
  output logic                 mem_we_o,
  output logic [`ADDR_BUS-1:0] mem_addr_o,
  output logic [3:0]           mem_width_o,
  output logic [`DATA_BUS-1:0] mem_data_o,
  input  logic [`DATA_BUS-1:0] mem_data_i
);

  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t               state;
  logic                 gnt;
  logic                 last_gnt;
  logic                 own_vld;
  logic                 own;
  logic [7:0]           lock_cnt;
  logic [`DATA_BUS-1:0] hold0;
  logic [`DATA_BUS-1:0] hold1;

  logic       any_req;
  logic       own_keep;
  logic       sel_own;
  logic       sel_rr;
  logic       sel_m1;
  logic       win;
  logic       lock_g;
  logic       other_req;
  logic [7:0] cnt_inc;

  assign any_req   = m0_req_i | m1_req_i;
  assign own_keep  = own_vld & (own ? m1_req_i : m0_req_i);
  assign sel_own   = own_keep;
  assign sel_rr    = ~own_keep & m0_req_i & m1_req_i;
  assign sel_m1    = ~own_keep & ~m0_req_i & m1_req_i;
  assign lock_g    = gnt ? m1_lock_i : m0_lock_i;
  assign other_req = gnt ? m0_req_i : m1_req_i;
  // streak saturates so an uncontended lock never wraps
  assign cnt_inc   = (lock_cnt == LMAX) ? LMAX : lock_cnt + 8'd1;

  // pick the winner: owner first, else the port not granted last
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      sel_own: win = own;
      sel_rr:  win = ~last_gnt;
      sel_m1:  win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  // access sequencer: IDLE arbitrates, ISSUE drives mem, RESP acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      own_vld     <= 1'b0;
      own         <= 1'b0;
      lock_cnt    <= '0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      mem_data_o  <= '0;
      m0_ack_o    <= 1'b0;
      m1_ack_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (own_vld && !own_keep) begin
            own_vld  <= 1'b0;
            lock_cnt <= '0;
          end
          if (any_req) begin
            state       <= ISSUE;
            gnt         <= win;
            mem_ce_o    <= 1'b1;
            mem_we_o    <= win ? m1_we_i : m0_we_i;
            mem_addr_o  <= win ? m1_addr_i : m0_addr_i;
            mem_width_o <= win ? m1_width_i : m0_width_i;
            mem_data_o  <= win ? m1_wdata_i : m0_wdata_i;
          end
        end
        ISSUE: begin
          state    <= RESP;
          mem_ce_o <= 1'b0;
          m0_ack_o <= ~gnt;
          m1_ack_o <= gnt;
        end
        RESP: begin
          state    <= IDLE;
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
          last_gnt <= gnt;
          if (lock_g && !(cnt_inc == LMAX && other_req)) begin
            own_vld  <= 1'b1;
            own      <= gnt;
            lock_cnt <= cnt_inc;
          end else begin
            own_vld  <= 1'b0;
            lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read data hold registers, loaded at the end of a read RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else if (state == RESP && !mem_we_o) begin
      if (gnt) hold1 <= mem_data_i;
      else     hold0 <= mem_data_i;
    end
  end

  assign m0_rdata_o = (m0_ack_o && !mem_we_o) ? mem_data_i : hold0;
  assign m1_rdata_o = (m1_ack_o && !mem_we_o) ? mem_data_i : hold1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against mem_arbiter,
// checked by a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int LOCK_MAX = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic        lock  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  width [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_width;
  logic [31:0] mem_data;
  logic [31:0] sram_q;
  logic [31:0] sram [256];

  mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req_i   (req[0]),
    .m0_we_i    (we[0]),
    .m0_addr_i  (addr[0]),
    .m0_width_i (width[0]),
    .m0_wdata_i (wdata[0]),
    .m0_lock_i  (lock[0]),
    .m0_ack_o   (ack[0]),
    .m0_rdata_o (rdata[0]),
    .m1_req_i   (req[1]),
    .m1_we_i    (we[1]),
    .m1_addr_i  (addr[1]),
    .m1_width_i (width[1]),
    .m1_wdata_i (wdata[1]),
    .m1_lock_i  (lock[1]),
    .m1_ack_o   (ack[1]),
    .m1_rdata_o (rdata[1]),
    .mem_ce_o   (mem_ce),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_width_o(mem_width),
    .mem_data_o (mem_data),
    .mem_data_i (sram_q)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // synchronous sram; the image is restored while reset is held
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= pat(i);
      sram_q <= '0;
    end else if (mem_ce) begin
      if (mem_we) sram[mem_addr[9:2]] <= mem_data;
      else        sram_q <= sram[mem_addr[9:2]];
    end
  end

  int          checks;
  int          errors;
  int          cyc;
  int          iss_cyc;
  int          ack_cyc;
  int          iss_p;
  int          last;
  int          owner;
  int          streak;
  int          gap   [2];
  int          raise [2];
  bit          gaps_on;
  bit          lock_rand;
  bit          chk_wait;
  logic        lock_val [2];
  logic [31:0] hold [2];
  logic [31:0] ref_w [int];
  txn_t        cur;
  txn_t        q0 [$];
  txn_t        q1 [$];
  int          alog [$];
  int          acyc [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int i;
    i = int'(a[9:2]);
    return ref_w.exists(i) ? ref_w[i] : pat(i);
  endfunction

  function automatic int qsize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  task automatic add(input int p, input logic w, input logic [31:0] a,
                     input logic [3:0] wd, input logic [31:0] d);
    txn_t t;
    t.we = w;
    t.addr = a;
    t.width = wd;
    t.wdata = d;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic present(input int p);
    txn_t t;
    t = (p == 0) ? q0[0] : q1[0];
    req[p]   = 1'b1;
    we[p]    = t.we;
    addr[p]  = t.addr;
    width[p] = t.width;
    wdata[p] = t.wdata;
    raise[p] = cyc;
  endtask

  task automatic drop_head(input int p);
    if (p == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; lock[p] = 1'b0;
      addr[p] = '0; wdata[p] = '0; width[p] = '0;
      hold[p] = '0; gap[p] = 0; raise[p] = 0;
    end
    q0.delete();
    q1.delete();
    ref_w.delete();
    iss_cyc = -10;
    ack_cyc = -10;
    last = 1;
    owner = -1;
    streak = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // one cycle: check outputs, move requesters, advance the model
  task automatic step();
    logic ea [2];
    int   w;
    @(negedge clk);
    cyc++;
    chk("ce", 32'(mem_ce), (cyc == iss_cyc) ? 32'd1 : 32'd0);
    if (cyc == iss_cyc) begin
      chk("mem_we", 32'(mem_we), 32'(cur.we));
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_width", 32'(mem_width), 32'(cur.width));
      chk("mem_data", mem_data, cur.wdata);
    end
    for (int p = 0; p < 2; p++) begin
      ea[p] = (cyc == ack_cyc) && (iss_p == p);
      chk(p == 0 ? "ack0" : "ack1", 32'(ack[p]), 32'(ea[p]));
      if (ea[p] && !cur.we) hold[p] = ref_rd(cur.addr);
      if (ea[p] && cur.we) ref_w[int'(cur.addr[9:2])] = cur.wdata;
      chk(p == 0 ? "rdata0" : "rdata1", rdata[p], hold[p]);
      if (ack[p] === 1'b1) begin
        alog.push_back(p);
        acyc.push_back(cyc);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (ea[p]) begin
        drop_head(p);
        if (qsize(p) == 0) begin
          req[p] = 1'b0;
        end else if (gaps_on && $urandom_range(0, 3) == 0) begin
          req[p] = 1'b0;
          gap[p] = int'($urandom_range(0, 2));
        end else begin
          present(p);
        end
      end else if (!req[p]) begin
        if (gap[p] > 0) gap[p]--;
        else if (qsize(p) > 0) present(p);
      end
      if (lock_rand) lock[p] = 1'($urandom_range(0, 1));
      else           lock[p] = lock_val[p];
    end
    if (cyc == ack_cyc) begin
      last = iss_p;
      if (lock[iss_p]) begin
        streak = (streak < LOCK_MAX) ? streak + 1 : LOCK_MAX;
        owner = iss_p;
        if (streak == LOCK_MAX && req[1 - iss_p]) begin
          owner = -1;
          streak = 0;
        end
      end else begin
        owner = -1;
        streak = 0;
      end
    end else if (cyc > ack_cyc) begin
      if (owner >= 0 && !req[owner]) begin
        owner = -1;
        streak = 0;
      end
      if (req[0] || req[1]) begin
        if (owner >= 0)            w = owner;
        else if (req[0] && req[1]) w = 1 - last;
        else                       w = req[0] ? 0 : 1;
        iss_p = w;
        iss_cyc = cyc + 1;
        ack_cyc = cyc + 2;
        cur.we = we[w];
        cur.addr = addr[w];
        cur.width = width[w];
        cur.wdata = wdata[w];
        if (chk_wait)
          chk("wait_le6", (ack_cyc - raise[w] <= 6) ? 32'd1 : 32'd0,
              32'd1);
      end
    end
  endtask

  task automatic run(input string tag, input int maxc);
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) > 0 || cyc <= ack_cyc) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'(qsize(0) + qsize(1) + ((cyc <= ack_cyc) ? 1 : 0)), 32'd0);
  endtask

  initial begin
    int          lk_exp [6];
    int          ones;
    int          n;
    logic [31:0] h1;
    lk_exp = '{0, 0, 0, 0, 1, 0};
    checks = 0;
    errors = 0;
    gaps_on = 1'b0;
    lock_rand = 1'b0;
    chk_wait = 1'b0;
    lock_val[0] = 1'b0;
    lock_val[1] = 1'b0;

    do_reset();
    chk("rst_ce", 32'(mem_ce), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_width", 32'(mem_width), 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_ack0", 32'(ack[0]), 32'd0);
    chk("rst_ack1", 32'(ack[1]), 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_rdata1", rdata[1], 32'd0);

    alog.delete();
    acyc.delete();
    add(0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);
    run("single_drain", 20);
    chk("single_n", 32'(alog.size()), 32'd1);
    if (acyc.size() > 0) chk("single_at", 32'(acyc[0]), 32'd3);
    chk("single_rdata", rdata[0], pat(1));

    do_reset();
    chk_wait = 1'b1;
    alog.delete();
    acyc.delete();
    for (int i = 0; i < 6; i++) begin
      add(0, 1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 4'hF, 32'h0);
      add(1, 1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 4'h3, 32'h0);
    end
    run("cont_drain", 100);
    chk_wait = 1'b0;
    chk("cont_n", 32'(alog.size()), 32'd12);
    for (int i = 0; i < alog.size(); i++) begin
      chk("cont_order", 32'(alog[i]), 32'(i % 2));
      if (i > 0) chk("cont_gap", 32'(acyc[i] - acyc[i - 1]), 32'd3);
    end

    h1 = hold[1];
    add(1, 1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF);
    run("wr_drain", 20);
    add(0, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
    run("rd_drain", 20);
    chk("wr_rd", rdata[0], 32'hDEAD_BEEF);
    chk("m1_hold", rdata[1], h1);

    lock_val[0] = 1'b1;
    gap[1] = 1;
    alog.delete();
    acyc.delete();
    for (int i = 0; i < 8; i++)
      add(0, 1'b0, 32'(i * 4), 4'hF, 32'h0);
    for (int i = 0; i < 3; i++)
      add(1, 1'b0, 32'h100 + 32'(i * 4), 4'h1, 32'h0);
    run("lock_drain", 200);
    chk("lock_n", 32'(alog.size()), 32'd11);
    for (int i = 0; i < 6 && i < alog.size(); i++)
      chk("lock_order", 32'(alog[i]), 32'(lk_exp[i]));

    alog.delete();
    acyc.delete();
    for (int i = 0; i < 20; i++)
      add(0, 1'b0, 32'h200 + 32'(i * 4), 4'hF, 32'h0);
    run("nolock_drain", 200);
    ones = 0;
    foreach (alog[i]) ones += alog[i];
    chk("nolock_n", 32'(alog.size()), 32'd20);
    chk("nolock_m1", 32'(ones), 32'd0);
    lock_val[0] = 1'b0;

    gaps_on = 1'b1;
    lock_rand = 1'b1;
    gap[0] = int'($urandom_range(0, 3));
    gap[1] = int'($urandom_range(0, 3));
    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++)
        add(p, 1'($urandom_range(0, 1)),
            {22'd0, 8'($urandom_range(0, 255)), 2'b00},
            4'($urandom_range(0, 15)), $urandom);
    end
    run("rand_drain", 3000);
    gaps_on = 1'b0;
    lock_rand = 1'b0;

    add(0, 1'b0, 32'h0000_0008, 4'hF, 32'h0);
    n = 0;
    do begin
      step();
      n++;
    end while (cyc != iss_cyc && n < 10);
    chk("iss_seen", (cyc == iss_cyc) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk("rsti_ce", 32'(mem_ce), 32'd0);
    chk("rsti_ack0", 32'(ack[0]), 32'd0);
    chk("rsti_addr", mem_addr, 32'd0);
    @(negedge clk);
    chk("rsti_noack", 32'(ack[0]), 32'd0);
    do_reset();
    alog.delete();
    acyc.delete();
    add(0, 1'b0, 32'h0000_000C, 4'hF, 32'h0);
    add(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    run("post_rst_drain", 20);
    chk("post_rst_n", 32'(alog.size()), 32'd2);
    if (alog.size() > 0) chk("post_rst_first", 32'(alog[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
